conv_acc_requant: RTL and testbench



---
 rtl/conv_acc_requant.sv | 132 +++++++++++++
 tb/tb_conv_acc_requant.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_acc_requant.sv
// Accumulates TAPS signed products plus a shifted bias, then rounds, shifts,
// optionally applies ReLU and saturates to an OUT_W-bit activation.
module conv_acc_requant #(
    parameter int PROD_W = 23,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 14,
    parameter int TAPS   = 9,
    parameter int SHIFT  = 8
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     clr,
    input  logic                     relu_en,
    input  logic signed [OUT_W-1:0]  bias_data,
    input  logic signed [PROD_W-1:0] prod_data,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sat_flag
);

    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
    localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(longint'(1) << (SHIFT - 1));
    localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((longint'(1) << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] OUT_MIN = (ACC_W+1)'(-(longint'(1) << (OUT_W - 1)));

    typedef enum logic [1:0] {S_ACC, S_RND, S_OUT} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          tap_cnt_q, tap_cnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [OUT_W-1:0]   out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      sat_q, sat_d;

    logic signed [ACC_W-1:0]   bias_sh;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W:0]     rnd;
    logic                      clipped;

    // Rounding add is done one bit wider so acc near +max cannot wrap.
    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] t;
        t = {a[ACC_W-1], a} + HALF;
        return t >>> SHIFT;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W:0] r);
        if (r > OUT_MAX) return OUT_MAX[OUT_W-1:0];
        if (r < OUT_MIN) return OUT_MIN[OUT_W-1:0];
        return r[OUT_W-1:0];
    endfunction

    assign bias_sh  = {{(ACC_W-OUT_W){bias_data[OUT_W-1]}}, bias_data} <<< SHIFT;
    assign prod_ext = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};

    always_comb begin
        state_d     = state_q;
        tap_cnt_d   = tap_cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;
        prod_ready  = 1'b0;
        rnd         = round_shift(acc_q);
        if (relu_en && rnd[ACC_W]) rnd = '0;
        clipped     = (rnd > OUT_MAX) || (rnd < OUT_MIN);

        if (clr) begin
            state_d     = S_ACC;
            tap_cnt_d   = '0;
            acc_d       = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
            sat_d       = 1'b0;
        end else begin
            case (state_q)
                S_ACC: begin
                    prod_ready = 1'b1;
                    if (prod_valid) begin
                        acc_d = ((tap_cnt_q == '0) ? bias_sh : acc_q) + prod_ext;
                        if (tap_cnt_q == LAST_TAP) begin
                            tap_cnt_d = '0;
                            state_d   = S_RND;
                        end else begin
                            tap_cnt_d = tap_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_RND: begin
                    out_data_d  = saturate(rnd);
                    out_valid_d = 1'b1;
                    if (clipped) sat_d = 1'b1;
                    state_d     = S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_ACC;
                    end
                end
                default: state_d = S_ACC;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= S_ACC;
            tap_cnt_q   <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_cnt_q   <= tap_cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_conv_acc_requant.sv
// Randomized + directed bench for conv_acc_requant against an arithmetic
// reference model of the window sum / round / relu / saturate rules.
module tb_conv_acc_requant;

    localparam int PROD_W = 23;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 14;
    localparam int TAPS   = 9;
    localparam int SHIFT  = 8;

    logic                     ap_clk = 1'b0;
    logic                     ap_rst_n = 1'b0;
    logic                     clr = 1'b0;
    logic                     relu_en = 1'b0;
    logic signed [OUT_W-1:0]  bias_data = '0;
    logic signed [PROD_W-1:0] prod_data = '0;
    logic                     prod_valid = 1'b0;
    logic                     prod_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic                     sat_flag;

    typedef struct {
        int out;
        bit sat;
    } exp_t;

    exp_t exp_q[$];
    bit   model_sat = 1'b0;
    bit   rand_rdy  = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    conv_acc_requant #(
        .PROD_W(PROD_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .TAPS(TAPS), .SHIFT(SHIFT)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .clr       (clr),
        .relu_en   (relu_en),
        .bias_data (bias_data),
        .prod_data (prod_data),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_flag  (sat_flag)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: exact integer window sum, 32-bit wrap, round-half-up divide.
    function automatic exp_t model(input int bias, input bit relu, input int p[$]);
        exp_t   e;
        longint acc, t, r;
        acc = longint'(bias) * (longint'(1) << SHIFT);
        foreach (p[i]) acc += p[i];
        acc = longint'(int'(acc));
        t = acc + (longint'(1) << (SHIFT - 1));
        if (t >= 0) r = t / (longint'(1) << SHIFT);
        else        r = -((-t + (longint'(1) << SHIFT) - 1) / (longint'(1) << SHIFT));
        if (relu && r < 0) r = 0;
        if (r > 8191)       begin r = 8191;  model_sat = 1'b1; end
        else if (r < -8192) begin r = -8192; model_sat = 1'b1; end
        e.out = int'(r);
        e.sat = model_sat;
        return e;
    endfunction

    // Called at/just after a falling edge; returns on the falling edge after the accept.
    task automatic push(input int d, input int b);
        int guard = 0;
        prod_valid = 1'b1;
        prod_data  = PROD_W'(d);
        bias_data  = OUT_W'(b);
        while (!prod_ready && guard < 200) begin
            @(negedge ap_clk);
            guard++;
        end
        if (guard >= 200) check("push_timeout", 1, 0);
        @(negedge ap_clk);
        prod_valid = 1'b0;
    endtask

    task automatic run_window(input int bias, input bit relu, input int p[$]);
        exp_q.push_back(model(bias, relu, p));
        foreach (p[i]) begin
            push(p[i], (i == 0) ? bias : $urandom_range(0, 16383) - 8192);
            if (i == 0) relu_en = relu;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge ap_clk);
            guard++;
        end
        check("drain", exp_q.size(), 0);
        @(negedge ap_clk);
    endtask

    task automatic do_clr();
        clr        = 1'b1;
        prod_valid = 1'b1;
        prod_data  = PROD_W'(5);
        #1;
        check("clr_prod_ready", prod_ready, 0);
        @(negedge ap_clk);
        clr        = 1'b0;
        prod_valid = 1'b0;
        model_sat  = 1'b0;
        #1;
        check("clr_sat", sat_flag, 0);
        check("clr_out_valid", out_valid, 0);
    endtask

    always begin
        @(negedge ap_clk);
        #1;
        if (ap_rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_output", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", out_data, e.out);
                check("sat_flag", sat_flag, e.sat);
            end
        end
    end

    always @(negedge ap_clk) if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);

    initial begin
        int w[$];
        int v;

        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sat", sat_flag, 0);
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check("rst_prod_ready", prod_ready, 1);

        // 1: nine x 256, latency and ready gap
        w.delete();
        repeat (TAPS) w.push_back(256);
        run_window(0, 0, w);
        #1;
        check("t1_rdy_n1", prod_ready, 0);
        check("t1_vld_n1", out_valid, 0);
        @(negedge ap_clk); #1;
        check("t1_vld_n2", out_valid, 1);
        check("t1_data_n2", out_data, 9);
        check("t1_rdy_n2", prod_ready, 0);
        @(negedge ap_clk); #1;
        check("t1_rdy_n3", prod_ready, 1);
        check("t1_vld_n3", out_valid, 0);

        // 2: rounding and bias
        foreach (w[i]) w[i] = 0;
        w[0] = 384;  run_window(0, 0, w);
        w[0] = -384; run_window(0, 0, w);
        w[0] = 128;  run_window(0, 0, w);
        w[0] = -129; run_window(0, 0, w);
        w[0] = 0;    run_window(3, 0, w);
        drain();

        // 3: saturation both directions
        foreach (w[i]) w[i] = 4194303;
        run_window(0, 0, w);
        drain();
        do_clr();
        foreach (w[i]) w[i] = -4194304;
        run_window(0, 0, w);
        drain();
        do_clr();

        // 4: relu
        foreach (w[i]) w[i] = 0;
        w[0] = -1000;
        run_window(0, 1, w);
        run_window(0, 0, w);
        drain();
        check("t4_sat", sat_flag, 0);

        // 5: output backpressure with next product waiting
        out_ready = 1'b0;
        foreach (w[i]) w[i] = 256;
        w[TAPS-1] = 512;
        run_window(0, 0, w);
        prod_valid = 1'b1;
        prod_data  = PROD_W'(100);
        bias_data  = '0;
        v = 0;
        while (!out_valid && v < 20) begin
            @(negedge ap_clk); #1;
            v++;
        end
        check("t5_valid_seen", out_valid, 1);
        repeat (5) begin
            check("t5_hold_vld", out_valid, 1);
            check("t5_hold_data", out_data, 10);
            check("t5_hold_rdy", prod_ready, 0);
            @(negedge ap_clk); #1;
        end
        out_ready = 1'b1;
        @(negedge ap_clk); #1;
        check("t5_resume_rdy", prod_ready, 1);
        w[0] = 100;
        w[TAPS-1] = 256;
        run_window(0, 0, w);
        drain();

        // 6: async reset and clr in the middle of a window
        repeat (4) push(1000, 0);
        #2 ap_rst_n = 1'b0;
        #1;
        check("t6_rst_vld", out_valid, 0);
        check("t6_rst_data", out_data, 0);
        @(negedge ap_clk);
        ap_rst_n  = 1'b1;
        model_sat = 1'b0;
        @(negedge ap_clk);
        foreach (w[i]) w[i] = 256;
        run_window(0, 0, w);
        drain();
        repeat (4) push(1000, 0);
        do_clr();
        @(negedge ap_clk);
        run_window(0, 0, w);
        drain();

        // Random windows with random downstream readiness
        rand_rdy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int b;
            int mode;
            mode = $urandom_range(0, 2);
            b = (mode == 0) ? $urandom_range(0, 16383) - 8192 : $urandom_range(0, 40) - 20;
            foreach (w[i]) begin
                if (mode == 2) w[i] = $urandom_range(0, 1000) - 500;
                else           w[i] = $urandom_range(0, (1 << PROD_W) - 1) - (1 << (PROD_W - 1));
            end
            run_window(b, $urandom_range(0, 1), w);
        end
        rand_rdy  = 1'b0;
        @(negedge ap_clk);
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
